// File: rtl/program_counter_stack_pkg.sv
// pc_pkg: action encoding, priority decode and default parameters for program_counter_stack.
package pc_pkg;
  localparam int PC_WIDTH = 16;
  localparam int PC_STACK_DEPTH = 8;
  localparam int PC_RESET_VECTOR = 0;
  typedef enum logic [2:0] {ACT_HOLD, ACT_INC, ACT_LOAD, ACT_CALL, ACT_RET} pc_action_t;
  function automatic pc_action_t pc_decode(input logic load, input logic inc, input logic call, input logic ret);
    return ret ? ACT_RET : call ? ACT_CALL : load ? ACT_LOAD : inc ? ACT_INC : ACT_HOLD;
  endfunction
endpackage

// File: rtl/program_counter_stack_lifo_stack.sv
// lifo_stack: return-address LIFO; push when full and pop when empty are ignored, pop beats push.
module lifo_stack #(
  parameter int WIDTH = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int AW = $clog2(STACK_DEPTH);
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    empty = count_q == '0;
    full = count_q == CW'(STACK_DEPTH);
    do_pop = pop & ~empty;
    do_push = push & ~full & ~pop;
    count_d = do_pop ? count_q - CW'(1) : do_push ? count_q + CW'(1) : count_q;
    rdata = empty ? '0 : mem_q[AW'(count_q - CW'(1))];
  end
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= count_d;
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[AW'(count_q)] <= wdata;
  end
endmodule

// File: rtl/program_counter_stack.sv
// program_counter_stack: PC with hold/inc/load/call/ret and sticky stack error flags.
// Define PC_ERR_CLEAR_EN to add err_clear, which clears the flags unless a new error sets them.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int STACK_DEPTH = PC_STACK_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
`ifdef PC_ERR_CLEAR_EN
  input  logic             err_clear,
`endif
  output logic [WIDTH-1:0] out,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             overflow,
  output logic             underflow
);
  pc_action_t act;
  logic [WIDTH-1:0] out_q, out_d, rdata;
  logic ovf_q, ovf_d, unf_q, unf_d, clr;
`ifdef PC_ERR_CLEAR_EN
  assign clr = err_clear;
`else
  assign clr = 1'b0;
`endif
  lifo_stack #(.WIDTH(WIDTH), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset(reset), .push(act == ACT_CALL), .pop(act == ACT_RET),
    .wdata(out_q + WIDTH'(1)), .rdata(rdata), .empty(stack_empty), .full(stack_full)
  );
  always_comb begin
    act = pc_decode(load, inc, call, ret);
    out_d = act == ACT_RET  ? (stack_empty ? out_q : rdata) :
            act == ACT_CALL ? (stack_full ? out_q : in) :
            act == ACT_LOAD ? in :
            act == ACT_INC  ? out_q + WIDTH'(1) : out_q;
    ovf_d = (act == ACT_CALL && stack_full) | (ovf_q & ~clr);
    unf_d = (act == ACT_RET && stack_empty) | (unf_q & ~clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign out = out_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
endmodule
